uart_tx: RTL and testbench

8N1 UART transmitter driven by the shared 16x-oversample baud tick `b_tick`. It sits between the FIFO read side and the board TX pin, and is the counterpart of the UART receiver on the same `b_tick`. A one-entry holding register accepts the next byte while the current frame is on the line, so back-to-back frames go out with no idle gap between them.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx.sv | 156 +++++++++++++++
 tb/tb_uart_tx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//   uart_state_e       : frame FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   UART_TICKS_PER_BIT : b_tick pulses per bit period (16x oversample)
//   UART_DATA_BITS     : payload bits per frame (8N1)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_TICKS_PER_BIT = 16;
    localparam int UART_DATA_BITS     = 8;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter paced by the shared 16x-oversample baud tick.
// A one-entry holding register takes the next byte while the current frame
// is on the line, so back-to-back frames leave with no idle gap.
//   clk, reset   : system clock, asynchronous active-high reset
//   b_tick       : one-clk baud tick, TICKS_PER_BIT per bit period
//   i_tx_start   : write strobe for i_tx_data (taken only when o_tx_ready)
//   i_tx_data    : byte to send
//   o_tx         : registered serial line, idle high
//   o_tx_ready   : holding register empty
//   o_tx_busy    : a frame is in progress (FSM not in IDLE)
//   o_tx_done    : one-clk pulse on the edge that ends each stop bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = UART_TICKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       b_tick,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx,
    output logic       o_tx_ready,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam int CW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic          hold_valid_q, hold_valid_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          bit_end;

    // Last tick of the current bit period.
    assign bit_end = b_tick && (tick_cnt_q == TICK_LAST);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; that is what keeps this block free of latches.
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        done_d       = 1'b0;

        // Accept only into an empty holding register. Unloading needs
        // hold_valid_q set, so accept and unload never collide in one cycle.
        if (i_tx_start && !hold_valid_q) begin
            hold_data_d  = i_tx_data;
            hold_valid_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                // Frame start is aligned to a tick.
                if (b_tick && hold_valid_q) begin
                    shift_d      = hold_data_q;
                    hold_valid_d = 1'b0;
                    state_d      = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    state_d    = DATA;
                end else if (b_tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else if (b_tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    done_d     = 1'b1;
                    // A waiting byte starts its start bit on this same tick.
                    if (hold_valid_q) begin
                        shift_d      = hold_data_q;
                        hold_valid_d = 1'b0;
                        state_d      = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (b_tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered, so o_tx changes on the
        // same edge as the transition.
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make every flop sample the pre-edge
            // values computed above, independent of statement order.
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            tx_q         <= tx_d;
            done_q       <= done_d;
        end
    end

    assign o_tx       = tx_q;
    assign o_tx_ready = !hold_valid_q;
    assign o_tx_busy  = (state_q != IDLE);
    assign o_tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. A tick-domain reference model (ticks
// elapsed in the current frame, one holding slot) predicts every output
// each clk; an independent line decoder recovers bytes from o_tx by
// mid-bit sampling and compares them with the frames the model started.
module tb_uart_tx;

    localparam int TPB   = 16;
    localparam int FRAME = 10 * TPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       b_tick;
    logic       i_tx_start;
    logic [7:0] i_tx_data;
    logic       o_tx;
    logic       o_tx_ready;
    logic       o_tx_busy;
    logic       o_tx_done;

    uart_tx #(.TICKS_PER_BIT(TPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .b_tick     (b_tick),
        .i_tx_start (i_tx_start),
        .i_tx_data  (i_tx_data),
        .o_tx       (o_tx),
        .o_tx_ready (o_tx_ready),
        .o_tx_busy  (o_tx_busy),
        .o_tx_done  (o_tx_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: m_pos = ticks elapsed in the current frame, -1 = idle.
    int         m_pos = -1;
    logic [7:0] m_cur = '0;
    logic       m_hv  = 1'b0;
    logic [7:0] m_hd  = '0;
    logic       m_done = 1'b0;
    logic [7:0] exp_q[$];

    // Stimulus pacing.
    int tick_div = 3;
    bit tick_en  = 1'b1;
    int cyc      = 0;
    int tick_no  = 0;
    int done_ticks[$];

    // Line decoder state.
    int         dec_cnt = -1;
    logic [7:0] dec_byte = '0;
    int         rx_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_line();
        int b;
        if (m_pos < 0) return 1'b1;
        b = m_pos / TPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_pos  = -1;
        m_hv   = 1'b0;
        m_hd   = '0;
        m_done = 1'b0;
        exp_q.delete();
        dec_cnt = -1;
    endtask

    // One clk edge of the model, using the pre-edge holding state.
    task automatic model_update(input logic st, input logic [7:0] d, input logic tk);
        logic       hv_old;
        logic [7:0] hd_old;
        hv_old = m_hv;
        hd_old = m_hd;
        m_done = 1'b0;
        if (st && !hv_old) begin
            m_hv = 1'b1;
            m_hd = d;
        end
        if (tk) begin
            if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == FRAME) begin
                    m_done = 1'b1;
                    m_pos  = -1;
                end
            end
            if (m_pos < 0 && hv_old) begin
                m_pos = 0;
                m_cur = hd_old;
                m_hv  = 1'b0;
                exp_q.push_back(hd_old);
            end
        end
    endtask

    task automatic decode(input logic tk);
        if (!tk) return;
        if (dec_cnt < 0) begin
            if (o_tx == 1'b0) dec_cnt = 0;
        end else begin
            dec_cnt++;
            if (dec_cnt >= 24 && dec_cnt <= 136 && ((dec_cnt - 24) % TPB) == 0)
                dec_byte[(dec_cnt - 24) / TPB] = o_tx;
            if (dec_cnt == 152) begin
                check("rx_stop", 32'(o_tx), 32'd1);
                if (exp_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
                else check("rx_byte", 32'(dec_byte), 32'(exp_q.pop_front()));
                rx_cnt++;
                dec_cnt = -1;
            end
        end
    endtask

    // Drive one clk of inputs, advance the model, then check all outputs.
    task automatic step(input logic st, input logic [7:0] d);
        logic tk;
        tk = tick_en && ((cyc % tick_div) == 0);
        cyc++;
        i_tx_start = st;
        i_tx_data  = d;
        b_tick     = tk;
        @(posedge clk);
        model_update(st, d, tk);
        #1;
        if (tk) tick_no++;
        check("o_tx",       32'(o_tx),       32'(exp_line()));
        check("o_tx_ready", 32'(o_tx_ready), 32'(!m_hv));
        check("o_tx_busy",  32'(o_tx_busy),  32'(m_pos >= 0));
        check("o_tx_done",  32'(o_tx_done),  32'(m_done));
        if (o_tx_done) done_ticks.push_back(tick_no);
        decode(tk);
    endtask

    task automatic write_byte(input logic [7:0] d);
        int n = 0;
        while (!o_tx_ready && n < 5000) begin
            step(1'b0, 8'h00);
            n++;
        end
        if (n >= 5000) check("ready_timeout", 32'd1, 32'd0);
        step(1'b1, d);
    endtask

    task automatic run_until_pos(input int p);
        int n = 0;
        while (m_pos < p && n < 5000) begin
            step(1'b0, 8'h00);
            n++;
        end
        if (n >= 5000) check("pos_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((m_pos >= 0 || m_hv) && n < 20000) begin
            step(1'b0, 8'h00);
            n++;
        end
        if (n >= 20000) check("drain_timeout", 32'd1, 32'd0);
        repeat (8) step(1'b0, 8'h00);
    endtask

    initial begin
        int         rx0;
        logic       tx_before;
        logic [7:0] lb[3];

        reset = 1'b1;
        b_tick = 1'b0;
        i_tx_start = 1'b0;
        i_tx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx",    32'(o_tx),       32'd1);
        check("rst_ready", 32'(o_tx_ready), 32'd1);
        check("rst_busy",  32'(o_tx_busy),  32'd0);
        check("rst_done",  32'(o_tx_done),  32'd0);
        reset = 1'b0;
        repeat (4) step(1'b0, 8'h00);

        // Single 0x55 frame.
        done_ticks.delete();
        rx0 = rx_cnt;
        write_byte(8'h55);
        drain();
        check("55_frames", 32'(rx_cnt - rx0), 32'd1);
        check("55_dones",  32'(done_ticks.size()), 32'd1);
        check("55_ready",  32'(o_tx_ready), 32'd1);

        // 0xA5 then 0x3C during DATA: zero idle gap, dones one frame apart.
        done_ticks.delete();
        write_byte(8'hA5);
        run_until_pos(3 * TPB);
        write_byte(8'h3C);
        drain();
        check("b2b_dones", 32'(done_ticks.size()), 32'd2);
        if (done_ticks.size() == 2)
            check("b2b_gap", 32'(done_ticks[1] - done_ticks[0]), 32'(FRAME));

        // 0x11, 0x22 accepted; 0x33 strobed while full and dropped.
        rx0 = rx_cnt;
        write_byte(8'h11);
        write_byte(8'h22);
        step(1'b1, 8'h33);
        drain();
        check("drop_frames", 32'(rx_cnt - rx0), 32'd2);

        // Reset during data bit 4 of 0xF0, then a clean 0x0F frame.
        write_byte(8'hF0);
        run_until_pos(5 * TPB + 4);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_tx",    32'(o_tx),       32'd1);
        check("mid_rst_busy",  32'(o_tx_busy),  32'd0);
        check("mid_rst_ready", 32'(o_tx_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        rx0 = rx_cnt;
        write_byte(8'h0F);
        drain();
        check("post_rst_frames", 32'(rx_cnt - rx0), 32'd1);

        // Loopback-style decode of edge patterns.
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h81;
        rx0 = rx_cnt;
        done_ticks.delete();
        for (int i = 0; i < 3; i++) write_byte(lb[i]);
        drain();
        check("lb_frames", 32'(rx_cnt - rx0), 32'd3);
        check("lb_dones",  32'(done_ticks.size()), 32'd3);

        // Tick stall of 1000 clk mid-frame.
        rx0 = rx_cnt;
        write_byte(8'h96);
        run_until_pos(4 * TPB + 7);
        tx_before = o_tx;
        tick_en = 1'b0;
        repeat (1000) step(1'b0, 8'h00);
        check("stall_tx", 32'(o_tx), 32'(tx_before));
        tick_en = 1'b1;
        drain();
        check("stall_frames", 32'(rx_cnt - rx0), 32'd1);

        // Randomized strobes and data at varying tick spacing.
        for (int r = 0; r < 4; r++) begin
            tick_div = int'($urandom_range(2, 4));
            repeat (2500) step($urandom_range(0, 15) == 0, 8'($urandom));
            drain();
        end
        check("final_expq_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
